// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and helpers for the PS/2 key encoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int unsigned KEY_W   = 11;
    localparam int unsigned KEY_TOG = 10;
    localparam int unsigned KEY_PRS = 9;
    localparam int unsigned KEY_EXT = 8;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        REL,
        EXTREL,
        SKIP
    } kfsm_t;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronise, deglitch, deserialise one 11-bit frame,
// check start/parity/stop and abandon frames that stall mid-way.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_bad
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned NBITS = 10;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          clk_prev;

    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tcnt;

    logic fall_c;
    logic frame_done_c;
    logic frame_good_c;
    logic timeout_c;

    // Two-flop synchroniser followed by a hold-for-FILTER_LEN-samples filter per line.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_a   <= '1;
            sync_b   <= '1;
            filt     <= '1;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            sync_a   <= {ps2_data, ps2_clk};
            sync_b   <= sync_a;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall_c       = clk_prev & ~filt[0];
    assign frame_done_c = fall_c && (bit_cnt == 4'(NBITS));
    assign frame_good_c = !shreg[0] && filt[1] && odd_parity_ok(shreg[9:1]);
    assign timeout_c    = !fall_c && (bit_cnt != '0) && (tcnt == TW'(TIMEOUT_CYC - 1));

    // Shift in bits on each filtered clock fall; the stop bit is taken live from the line.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
            data_byte  <= '0;
        end else begin
            byte_valid <= frame_done_c & frame_good_c;
            frame_bad  <= (frame_done_c & ~frame_good_c) | timeout_c;
            if (fall_c) begin
                tcnt <= '0;
                if (frame_done_c) begin
                    bit_cnt   <= '0;
                    data_byte <= shreg[8:1];
                end else begin
                    shreg   <= {filt[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout_c) begin
                bit_cnt <= '0;
                tcnt    <= '0;
            end else if (bit_cnt != '0) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to ps2_key[10:0] event bus: folds E0/F0/E1 prefixes into one
// toggle-flagged make/break event and counts discarded frames.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             key_strobe,
    output logic             frame_err,
    output logic [7:0]       err_count
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_bad;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .data_byte (rx_byte),
        .frame_bad (frame_bad)
    );

    kfsm_t            state;
    kfsm_t            state_d;
    logic [2:0]       skip_cnt;
    logic [2:0]       skip_d;
    logic [KEY_W-1:0] key_d;
    logic             strobe_d;
    logic             err_d;
    logic [7:0]       count_d;

    logic       emit_c;
    logic       emit_ext;
    logic       emit_prs;
    logic [7:0] emit_code;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            skip_cnt   <= '0;
            ps2_key    <= '0;
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            skip_cnt   <= skip_d;
            ps2_key    <= key_d;
            key_strobe <= strobe_d;
            frame_err  <= err_d;
            err_count  <= count_d;
        end
    end

    // Prefix folding; a bad frame abandons any prefix in progress.
    always_comb begin
        state_d   = state;
        skip_d    = skip_cnt;
        key_d     = ps2_key;
        strobe_d  = 1'b0;
        err_d     = frame_bad;
        count_d   = err_count;
        emit_c    = 1'b0;
        emit_ext  = 1'b0;
        emit_prs  = 1'b1;
        emit_code = rx_byte;

        if (frame_bad) begin
            state_d = IDLE;
            if (err_count != 8'hFF) begin
                count_d = err_count + 8'd1;
            end
        end else if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = EXT;
                    end else if (rx_byte == PS2_REL) begin
                        state_d = REL;
                    end else if (rx_byte == PS2_PAUSE) begin
                        state_d = SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        emit_c = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_byte == PS2_REL) begin
                        state_d = EXTREL;
                    end else begin
                        emit_c   = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                REL: begin
                    emit_c   = 1'b1;
                    emit_prs = 1'b0;
                end
                EXTREL: begin
                    emit_c   = 1'b1;
                    emit_ext = 1'b1;
                    emit_prs = 1'b0;
                end
                SKIP: begin
                    skip_d = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        emit_c    = 1'b1;
                        emit_ext  = 1'b1;
                        emit_code = PAUSE_CODE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit_c) begin
            key_d[KEY_TOG] = ~ps2_key[KEY_TOG];
            key_d[KEY_PRS] = emit_prs;
            key_d[KEY_EXT] = emit_ext;
            key_d[7:0]     = emit_code;
            strobe_d       = 1'b1;
            state_d        = IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: PS/2 frame driver, prefix-folding
// reference model on a pending-byte list, table vectors and corner sequences.
module tb_ps2_key_encoder;

    localparam int unsigned HALF = 10;
    localparam int unsigned FAST = 8;
    localparam int unsigned NV   = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;
    logic [7:0]  err_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ps2_key_encoder dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .key_strobe(key_strobe),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: bytes since the last event, resolved by prefix rules.
    logic [7:0]  pend [$];
    logic [9:0]  exp_q [$];
    int unsigned m_err;

    function automatic void model_byte(input logic [7:0] b, input bit good);
        int unsigned idx;
        bit ext;
        bit rel;
        if (!good) begin
            pend.delete();
            if (m_err < 255) m_err++;
            return;
        end
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) begin
                exp_q.push_back(10'h377);
                pend.delete();
            end
            return;
        end
        idx = 0;
        ext = 1'b0;
        rel = 1'b0;
        if (pend[idx] == 8'hE0) begin
            ext = 1'b1;
            idx++;
        end
        if (idx < pend.size() && pend[idx] == 8'hF0) begin
            rel = 1'b1;
            idx++;
        end
        if (idx < pend.size()) begin
            exp_q.push_back({~rel, ext, pend[idx]});
            pend.delete();
        end
    endfunction

    // Event monitor: every strobe must match the next modelled event, toggle = event parity.
    int unsigned strobes = 0;
    int unsigned errs    = 0;
    int unsigned ev_cnt  = 0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            ev_cnt = 0;
        end else begin
            if (frame_err) errs++;
            if (key_strobe) begin
                logic [9:0] e;
                strobes++;
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got ps2_key 0x%0h, no event expected", ps2_key);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'(ps2_key), 32'({ev_cnt[0], e}));
                end
            end
        end
    end

    task automatic ps2_bit(input logic v, input int unsigned half, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            repeat (4) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int unsigned half, input bit glitch);
        logic [10:0] f;
        logic p;
        p = (~(^b)) ^ bad;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i], half, glitch);
        ps2_data = 1'b1;
        repeat (half) @(negedge clk_sys);
    endtask

    task automatic send(input logic [7:0] b, input bit good);
        model_byte(b, good);
        send_frame(b, !good, HALF, 1'b0);
    endtask

    task automatic partial(input int unsigned n);
        for (int i = 0; i < int'(n); i++) ps2_bit(1'($urandom_range(0, 1)), HALF, 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset(input bit check);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        if (check) begin
            chk("reset_key", 32'(ps2_key), 32'h0);
            chk("reset_strobe", 32'(key_strobe), 32'h0);
            chk("reset_frame_err", 32'(frame_err), 32'h0);
            chk("reset_err_count", 32'(err_count), 32'h0);
        end
        pend.delete();
        exp_q.delete();
        m_err = 0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    typedef struct {
        logic [7:0]  seq [3];
        int unsigned n;
        logic [9:0]  exp;
    } vec_t;
    vec_t vec [NV];

    function automatic void set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input int unsigned n, input logic [9:0] e);
        vec[i].seq[0] = b0;
        vec[i].seq[1] = b1;
        vec[i].seq[2] = b2;
        vec[i].n      = n;
        vec[i].exp    = e;
    endfunction

    initial begin
        int unsigned s0;
        int unsigned e0;
        logic [7:0] b;
        int unsigned r;

        set_vec(0, 8'h29, 8'h00, 8'h00, 1, 10'h229);
        set_vec(1, 8'hE0, 8'h75, 8'h00, 2, 10'h375);
        set_vec(2, 8'hE0, 8'hF0, 8'h75, 3, 10'h175);
        set_vec(3, 8'hF0, 8'h1C, 8'h00, 2, 10'h01C);
        set_vec(4, 8'hF0, 8'hE0, 8'h00, 2, 10'h0E0);
        set_vec(5, 8'hE0, 8'hF0, 8'hF0, 3, 10'h1F0);
        set_vec(6, 8'hE0, 8'hE1, 8'h00, 2, 10'h3E1);
        set_vec(7, 8'h5A, 8'h00, 8'h00, 1, 10'h25A);

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_err    = 0;
        repeat (2) @(negedge clk_sys);
        do_reset(1'b1);

        // Single make code.
        s0 = strobes;
        send(8'h29, 1'b1);
        chk("space_key", 32'(ps2_key), 32'h629);
        chk("space_strobes", strobes - s0, 1);
        chk("space_err_count", 32'(err_count), 32'h0);

        // Extended make then extended break.
        s0 = strobes;
        send(8'hE0, 1'b1);
        send(8'h75, 1'b1);
        chk("ext_make", 32'(ps2_key[9:0]), 32'h375);
        send(8'hE0, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h75, 1'b1);
        chk("ext_break", 32'(ps2_key[9:0]), 32'h175);
        chk("ext_strobes", strobes - s0, 2);

        for (int t = 0; t < int'(NV); t++) begin
            s0 = strobes;
            for (int j = 0; j < int'(vec[t].n); j++) send(vec[t].seq[j], 1'b1);
            chk($sformatf("vec%0d_key", t), 32'(ps2_key[9:0]), 32'(vec[t].exp));
            chk($sformatf("vec%0d_strobes", t), strobes - s0, 1);
        end

        // Parity error, then recovery.
        do_reset(1'b0);
        s0 = strobes;
        e0 = errs;
        send(8'h1C, 1'b0);
        chk("parity_strobes", strobes - s0, 0);
        chk("parity_err_pulses", errs - e0, 1);
        chk("parity_err_count", 32'(err_count), 32'h1);
        chk("parity_key_held", 32'(ps2_key), 32'h0);
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        chk("parity_recover", 32'(ps2_key), 32'h41C);

        // Stalled frame times out.
        do_reset(1'b0);
        s0 = strobes;
        e0 = errs;
        model_byte(8'h00, 1'b0);
        partial(5);
        repeat (10000) @(negedge clk_sys);
        chk("stall_err_pulses", errs - e0, 1);
        send(8'h16, 1'b1);
        chk("stall_key", 32'(ps2_key), 32'h616);
        chk("stall_err_count", 32'(err_count), 32'h1);
        chk("stall_strobes", strobes - s0, 1);

        // Short clock glitches between bits.
        model_byte(8'h4B, 1'b1);
        send_frame(8'h4B, 1'b0, HALF, 1'b1);
        chk("glitch_key", 32'(ps2_key[9:0]), 32'h24B);

        // Reset mid-prefix and mid-frame.
        send(8'hF0, 1'b1);
        do_reset(1'b1);
        send(8'h14, 1'b1);
        chk("reset_prefix_key", 32'(ps2_key), 32'h614);
        partial(4);
        do_reset(1'b0);
        send(8'h14, 1'b1);
        chk("reset_frame_key", 32'(ps2_key), 32'h614);

        // Pause sequence yields one event.
        do_reset(1'b0);
        s0 = strobes;
        send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
        send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
        chk("pause_strobes", strobes - s0, 1);
        chk("pause_key", 32'(ps2_key), 32'h777);

        // Random prefix-heavy stream with occasional bad frames.
        do_reset(1'b0);
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r < 5) b = 8'hE1;
            else            b = 8'($urandom_range(0, 255));
            send(b, $urandom_range(0, 7) != 0);
        end
        chk("random_pending", 32'(exp_q.size()), 32'h0);
        chk("random_err_count", 32'(err_count), 32'(m_err));

        // Error counter saturation with FILTER_LEN-wide clock phases.
        do_reset(1'b0);
        s0 = strobes;
        e0 = errs;
        for (int k = 0; k < 300; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, FAST, 1'b0);
        chk("sat_err_count", 32'(err_count), 32'hFF);
        chk("sat_err_pulses", errs - e0, 300);
        chk("sat_strobes", strobes - s0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
